// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, controller states and status-flag bundle for alu_pipe.
package alu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_MUL = 3'b111
    } alith_e;

    typedef enum logic [0:0] {IDLE, MUL_BUSY} state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic neg;
    } flags_t;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand (in_*) and result (out_*) handshakes of alu_pipe; master = producer/consumer side, slave = ALU.
interface alu_pipe_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alith;
    logic [WIDTH-1:0] source1;
    logic [WIDTH-1:0] source2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_ovf;
    logic             flag_neg;
    logic             op_err;

    modport master (
        output in_valid, alith, source1, source2, out_ready,
        input  in_ready, out_valid, alu_out, flag_zero, flag_carry, flag_ovf, flag_neg, op_err
    );

    modport slave (
        input  in_valid, alith, source1, source2, out_ready,
        output in_ready, out_valid, alu_out, flag_zero, flag_carry, flag_ovf, flag_neg, op_err
    );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per cycle, WIDTH steps after start.
module alu_mul_seq #(parameter int WIDTH = 16) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH);
    logic               busy;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    // done stays high until the next start so the owner can wait for a free output slot
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            done    <= 1'b0;
            cnt     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            product <= '0;
        end else if (busy) begin
            product <= product + (mplier[0] ? mcand : '0);
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + CW'(1);
            busy    <= cnt != CW'(WIDTH - 1);
            done    <= cnt == CW'(WIDTH - 1);
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready on both sides and status flags.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise MUL returns op_err in one cycle.
module alu_pipe import alu_pkg::*; #(parameter int WIDTH = 16) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    alith_e             op;
    alith_e             cop;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SW-1:0]      shamt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic [2*WIDTH-1:0] shl;
    logic [2*WIDTH-1:0] shr;
    logic [WIDTH-1:0]   res;
    flags_t             fl;
    logic               err;
    logic [WIDTH-1:0]   out_q;
    flags_t             fl_q;
    logic               err_q;
    logic               valid_q;
    logic               slot_free;
    logic               accept;
    logic               wr;

    assign op        = alith_e'(bus.alith);
    assign a         = bus.source1;
    assign b         = bus.source2;
    assign shamt     = b[SW-1:0];
    assign slot_free = !valid_q || bus.out_ready;
    assign accept    = bus.in_valid && bus.in_ready;

`ifdef ALU_MUL_EN
    localparam logic [0:0] ST_IDLE     = IDLE;
    localparam logic [0:0] ST_MUL_BUSY = MUL_BUSY;
    logic [0:0]         state;
    logic               mul_done;
    logic               mul_wr;
    logic [2*WIDTH-1:0] prod;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && op == ALU_MUL),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (prod)
    );

    assign bus.in_ready = state == ST_IDLE && slot_free;
    assign mul_wr       = state == ST_MUL_BUSY && mul_done && slot_free;
    assign wr           = (accept && op != ALU_MUL) || mul_wr;
    // the live op bus is unrelated to a finishing multiply, so force the MUL result path
    assign cop          = mul_wr ? ALU_MUL : op;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else if (accept && op == ALU_MUL)
            state <= ST_MUL_BUSY;
        else if (mul_wr)
            state <= ST_IDLE;
    end
`else
    assign bus.in_ready = slot_free;
    assign wr           = accept;
    assign cop          = op;
`endif

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} - {1'b0, b};
        shl = {{WIDTH{1'b0}}, a} << shamt;
        shr = {a, {WIDTH{1'b0}}} >> shamt;
        res = '0;
        fl  = '0;
        err = 1'b0;
        case (cop)
            ALU_ADD: begin
                res      = sum[WIDTH-1:0];
                fl.carry = sum[WIDTH];
                fl.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                res      = dif[WIDTH-1:0];
                fl.carry = dif[WIDTH];
                fl.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_SLL: begin
                res      = shl[WIDTH-1:0];
                fl.carry = |shamt && shl[WIDTH];
            end
            ALU_SRL: begin
                res      = shr[2*WIDTH-1:WIDTH];
                fl.carry = |shamt && shr[WIDTH-1];
            end
`ifdef ALU_MUL_EN
            ALU_MUL: begin
                res      = prod[WIDTH-1:0];
                fl.carry = |prod[2*WIDTH-1:WIDTH];
            end
`else
            ALU_MUL: err = 1'b1;
`endif
            default: ;
        endcase
        fl.zero = res == '0;
        fl.neg  = res[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            fl_q    <= '0;
            err_q   <= 1'b0;
        end else if (wr) begin
            valid_q <= 1'b1;
            out_q   <= res;
            fl_q    <= fl;
            err_q   <= err;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.alu_out    = out_q;
    assign bus.flag_zero  = fl_q.zero;
    assign bus.flag_carry = fl_q.carry;
    assign bus.flag_ovf   = fl_q.ovf;
    assign bus.flag_neg   = fl_q.neg;
    assign bus.op_err     = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed literal checks plus randomized traffic compared every cycle against a transaction-level model.
module tb_alu_pipe;
    localparam int W = 16;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         o;
        logic         n;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    alu_pipe_if #(.WIDTH(W)) bif ();
    alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        int unsigned ua, ub, full;
        int          sa, sb, sr, sh;
        e  = '0;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        sh = b % W;
        case (op)
            3'd0: begin full = ua + ub; e.res = full[W-1:0]; e.c = full > 32'hFFFF; sr = sa + sb; e.o = sr > 32767 || sr < -32768; end
            3'd1: begin full = ua - ub; e.res = full[W-1:0]; e.c = ua < ub; sr = sa - sb; e.o = sr > 32767 || sr < -32768; end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: begin e.res = 16'(ua << sh); e.c = sh != 0 && ((ua >> (W - sh)) & 1) != 0; end
            3'd6: begin e.res = 16'(ua >> sh); e.c = sh != 0 && ((ua >> (sh - 1)) & 1) != 0; end
            default: begin
                if (MUL_EN) begin full = ua * ub; e.res = full[W-1:0]; e.c = full > 32'hFFFF; end
                else e.err = 1'b1;
            end
        endcase
        e.z = e.res == 0;
        e.n = e.res[W-1];
        return e;
    endfunction

    // transaction-level model: one output slot plus an optional multiply in flight
    bit   m_valid = 0, m_busy = 0, last_acc = 0;
    int   m_cnt = 0;
    exp_t m_out = '0, m_pend = '0;

    always @(posedge clk) begin
        bit rdy, pop;
        last_acc = 0;
        if (rst) begin
            m_valid = 0; m_busy = 0; m_cnt = 0; m_out = '0;
        end else begin
            pop = m_valid && bif.out_ready;
            rdy = !m_busy && (!m_valid || bif.out_ready);
            if (m_busy) begin
                if (m_cnt == W && (!m_valid || bif.out_ready)) begin
                    m_out = m_pend; m_valid = 1; m_busy = 0;
                end else begin
                    if (m_cnt < W) m_cnt++;
                    if (pop) m_valid = 0;
                end
            end else if (bif.in_valid && rdy) begin
                last_acc = 1;
                if (MUL_EN && bif.alith == 3'd7) begin
                    m_busy = 1; m_cnt = 0;
                    m_pend = ref_alu(bif.alith, bif.source1, bif.source2);
                    if (pop) m_valid = 0;
                end else begin
                    m_out = ref_alu(bif.alith, bif.source1, bif.source2); m_valid = 1;
                end
            end else if (pop) m_valid = 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", bif.in_ready, !m_busy && (!m_valid || bif.out_ready));
        chk("out_valid", bif.out_valid, m_valid);
        chk("alu_out", bif.alu_out, m_out.res);
        chk("flags", {bif.flag_zero, bif.flag_carry, bif.flag_ovf, bif.flag_neg}, {m_out.z, m_out.c, m_out.o, m_out.n});
        chk("op_err", bif.op_err, m_out.err);
    end

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [3:0] ef, input logic ee, input int elat);
        int lat;
        bit got;
        bif.in_valid = 1; bif.alith = op; bif.source1 = a; bif.source2 = b; bif.out_ready = 1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            got = last_acc;
        end
        chk("accept", got, 1);
        bif.in_valid = 0;
        lat = 1;
        while (!bif.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, elat);
        chk("d_out", bif.alu_out, er);
        chk("d_flags", {bif.flag_zero, bif.flag_carry, bif.flag_ovf, bif.flag_neg}, ef);
        chk("d_err", bif.op_err, ee);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom % 8)
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bif.in_valid = 0; bif.alith = 0; bif.source1 = 0; bif.source2 = 0; bif.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_valid", bif.out_valid, 0);
        chk("rst_out", bif.alu_out, 0);
        chk("rst_flags", {bif.flag_zero, bif.flag_carry, bif.flag_ovf, bif.flag_neg}, 0);
        chk("rst_err", bif.op_err, 0);
        chk("rst_ready", bif.in_ready, 1);
        chk("pin_sub", ref_alu(3'd1, 16'd2, 16'd5).res, 16'hFFFD);
        chk("pin_srl", ref_alu(3'd6, 16'h0003, 16'h0011).c, 1);

        run(3'd0, 16'd1, 16'd2, 16'd3, 4'b0000, 0, 1);
        run(3'd1, 16'd5, 16'd2, 16'd3, 4'b0000, 0, 1);
        run(3'd2, 16'hC, 16'h8, 16'h8, 4'b0000, 0, 1);
        run(3'd3, 16'h8, 16'h1, 16'h9, 4'b0000, 0, 1);
        run(3'd4, 16'hF0F0, 16'h0FF0, 16'hFF00, 4'b0001, 0, 1);
        run(3'd1, 16'd2, 16'd5, 16'hFFFD, 4'b0101, 0, 1);
        run(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 0, 1);
        run(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 0, 1);
        run(3'd5, 16'h8001, 16'h0001, 16'h0002, 4'b0100, 0, 1);
        run(3'd6, 16'h0003, 16'h0011, 16'h0001, 4'b0100, 0, 1);
        run(3'd5, 16'h0001, 16'h0000, 16'h0001, 4'b0000, 0, 1);
`ifdef ALU_MUL_EN
        run(3'd7, 16'd300, 16'd300, 16'h5F90, 4'b0100, 0, 17);
`else
        run(3'd7, 16'd300, 16'd300, 16'h0000, 4'b1000, 1, 1);
`endif

        bif.in_valid = 1; bif.alith = 3'd0; bif.source1 = 4; bif.source2 = 4; bif.out_ready = 0;
        @(posedge clk); #1;
        chk("bp_acc", last_acc, 1);
        bif.source1 = 5; bif.source2 = 5;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_ready", bif.in_ready, 0);
            chk("bp_hold", bif.alu_out, 16'd8);
        end
        bif.out_ready = 1;
        @(posedge clk); #1;
        chk("b2b_1", bif.alu_out, 16'd10);
        bif.source1 = 6; bif.source2 = 6;
        @(posedge clk); #1;
        chk("b2b_2", bif.alu_out, 16'd12);
        chk("b2b_v", bif.out_valid, 1);
        bif.in_valid = 0;
        @(posedge clk); #1;
        chk("drain", bif.out_valid, 0);

        bif.in_valid = 1; bif.alith = 3'd7; bif.source1 = 16'd300; bif.source2 = 16'd300;
        @(posedge clk); #1;
        bif.in_valid = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort_valid", bif.out_valid, 0);
        chk("abort_ready", bif.in_ready, 1);
        repeat (20) begin
            @(posedge clk); #1;
            chk("abort_quiet", bif.out_valid, 0);
        end

        for (int i = 0; i < 3000; i++) begin
            if (!bif.in_valid || last_acc) begin
                bif.in_valid = ($urandom % 4) != 0;
                bif.alith    = 3'($urandom);
                bif.source1  = rnd_val();
                bif.source2  = ($urandom % 2) ? 16'($urandom % 20) : rnd_val();
            end
            bif.out_ready = ($urandom % 4) != 0;
            rst = ($urandom % 500) == 0;
            @(posedge clk); #1;
        end
        rst = 0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the combinational 16-bit ALU: a WIDTH-bit ALU with valid/ready handshakes on both sides, a 1-cycle result register, status flags, an extended op set, and an optional iterative multiplier. It sits between operand fetch and register writeback, and can stall either side.

## Interface
- WIDTH, 16: operand/result width (≥4, power of two).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block accepts operands this cycle.
- alith  in  3  op select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
- source1, source2  in  WIDTH  operands.
- out_valid  out  1  result held on outputs.
- out_ready  in  1  consumer takes result.
- alu_out  out  WIDTH  result.
- flag_zero, flag_carry, flag_ovf, flag_neg  out  1  status of alu_out.
- op_err  out  1  unsupported op.

## Operation
- States: IDLE, MUL_BUSY. Output register (alu_out, flags, op_err, out_valid) is separate from the state.
- Accept when in_valid && in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops: the result is registered on the accept edge.
- ADD: WIDTH-bit sum. carry = carry-out. ovf = signed overflow.
- SUB: source1 − source2. carry = borrow (source1 < source2 unsigned). ovf = signed overflow.
- AND/OR/XOR: bitwise. carry = 0, ovf = 0.
- SLL/SRL: shift source1 by source2[$clog2(WIDTH)-1:0]; upper bits of source2 are ignored; zero fill. carry = last bit shifted out (0 if amount 0). ovf = 0.
- flag_zero = (alu_out==0) and flag_neg = alu_out[WIDTH-1] for all ops.
- MUL: see Configuration. The result is the low WIDTH bits of the unsigned product. carry = 1 if any upper product bit is nonzero. ovf = 0.
- Reset values: out_valid=0, alu_out=0, all flags=0, op_err=0, state=IDLE, in_ready=1 on the first cycle after reset.

## Timing
- Single-cycle op: accepted at edge N → out_valid=1 after edge N (latency 1).
- Full throughput: 1 op/cycle while out_ready=1.
- Backpressure: out_valid && !out_ready holds the output stable and forces in_ready=0.
- Simultaneous pop and accept in the same cycle: the new result replaces the old at that edge, and out_valid stays 1.
- MUL with ALU_MUL_EN defined:
  - The accept edge enters MUL_BUSY with a counter at 0.
  - Each cycle performs one shift-add step.
  - After WIDTH steps, the result is written and state returns to IDLE.
  - out_valid asserts WIDTH+1 edges after accept (17 for WIDTH=16).
  - in_ready=0 throughout MUL_BUSY.
  - A pending output may still be popped during MUL_BUSY.
- Reset asserted mid-MUL: abort at that edge. No result is produced and all outputs take reset values.
- Inputs change only on accept; operands are captured at accept. Later source changes have no effect.

## Configuration
- ALU_MUL_EN defined: the iterative multiplier is compiled in and MUL behaves as above. op_err is never set.
- ALU_MUL_EN undefined: no multiplier logic and no MUL_BUSY state. MUL completes with latency 1, alu_out=0, all flags=0 except flag_zero=1, and op_err=1.

## Structure
- Package alu_pkg holds:
  - typedef enum logic [2:0] alith_e (ALU_ADD…ALU_MUL, encodings as above);
  - typedef enum state_e {IDLE, MUL_BUSY};
  - a flags struct.
- Sub-module alu_mul_seq: shift-add multiplier with start/done and a WIDTH-step counter. It is instantiated only under ALU_MUL_EN.

## Test plan
- ADD 1+2 → alu_out=3, out_valid one cycle after accept, flags all 0. SUB 5−2 → 3. AND 0xC&0x8 → 8. OR 0x8|0x1 → 9.
- SUB 2−5 → 0xFFFD, carry=1, neg=1. ADD 0x7FFF+0x0001 → 0x8000, ovf=1, neg=1. ADD 0xFFFF+1 → 0, carry=1, zero=1.
- SLL 0x8001 by 1 → 0x0002, carry=1. SRL 0x0003 with source2=0x0011 (amount 1) → 0x0001, carry=1.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and alu_out unchanged. Release → back-to-back ops retire one per cycle.
- With ALU_MUL_EN: MUL 300×300 → alu_out=0x5F90, carry=1, out_valid 17 edges after accept, in_ready=0 while busy. Without ALU_MUL_EN: MUL → alu_out=0, op_err=1, latency 1.
- Assert rst 5 cycles into a MUL → out_valid stays 0, no result is emitted, and in_ready=1 on the cycle after rst deasserts.
